// File: rtl/fpu_pkg.sv
// Shared floating-point definitions used by the FPU datapath blocks
// (float32 field layout, operand classes and integer range constants).
package fpu_pkg;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] man;
   } float_t;

   typedef enum logic [1:0] {
      FC_ZERO,
      FC_NORM,
      FC_BIG,
      FC_NAN
   } fclass_t;

   localparam logic [7:0]  BIAS    = 8'd127;
   localparam logic [7:0]  EXP_BIG = 8'd158;
   localparam logic [7:0]  EXP_MAX = 8'hFF;
   localparam logic [31:0] INT_MAX = 32'h7FFFFFFF;
   localparam logic [31:0] INT_MIN = 32'h80000000;

endpackage

// File: rtl/ftoi_classify.sv
// Combinational float32 classifier for integer conversion: decides whether
// the operand truncates to zero, converts normally, saturates or is NaN, and
// exposes the shift amount and hidden-bit mantissa for the shifter.
module ftoi_classify
   import fpu_pkg::*;
(
   input  float_t      f,
   output fclass_t     cls,
   output logic [4:0]  shamt,
   output logic [23:0] mant24,
   output logic        is_min
);

   logic [7:0] unbiased;

   // Classify by exponent range; -2^31 is the only BIG value that is representable
   always_comb begin
      unbiased = f.exp - BIAS;
      shamt    = unbiased[4:0];
      mant24   = {1'b1, f.man};
      is_min   = f.sign & (f.exp == EXP_BIG) & (f.man == 23'd0);
      cls      = FC_NORM;
      if ((f.exp == EXP_MAX) && (f.man != 23'd0)) begin
         cls = FC_NAN;
      end else if (f.exp >= EXP_BIG) begin
         cls = FC_BIG;
      end else if (f.exp < BIAS) begin
         cls = FC_ZERO;
      end
   end

endmodule

// File: rtl/ftoi_pipe.sv
// Two-stage pipelined float32 -> int32 converter (truncate toward zero)
// with valid/ready handshake on both sides and saturation reporting.
module ftoi_pipe
   import fpu_pkg::*;
#(
   parameter logic SAT_NAN = 1'b1
)
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] src,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] dest,
   output logic        ovf
);

   logic        adv1;
   logic        adv2;

   fclass_t     c_cls;
   logic [4:0]  c_shamt;
   logic [23:0] c_mant24;
   logic        c_is_min;

   logic        s1_valid;
   logic        s1_sign;
   fclass_t     s1_cls;
   logic [4:0]  s1_shamt;
   logic [23:0] s1_mant24;
   logic        s1_is_min;

   logic [31:0] mag;
   logic [31:0] res;
   logic        res_ovf;

   assign adv2     = ~out_valid | out_ready;
   assign adv1     = ~s1_valid | adv2;
   assign in_ready = adv1;

   ftoi_classify u_classify (
      .f      (float_t'(src)),
      .cls    (c_cls),
      .shamt  (c_shamt),
      .mant24 (c_mant24),
      .is_min (c_is_min)
   );

   // Stage 1: capture the classified operand whenever the stage can advance
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_valid  <= 1'b0;
         s1_sign   <= 1'b0;
         s1_cls    <= FC_ZERO;
         s1_shamt  <= 5'd0;
         s1_mant24 <= 24'd0;
         s1_is_min <= 1'b0;
      end else if (adv1) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_sign   <= src[31];
            s1_cls    <= c_cls;
            s1_shamt  <= c_shamt;
            s1_mant24 <= c_mant24;
            s1_is_min <= c_is_min;
         end
      end
   end

   // Align the mantissa to the binary point, then apply sign or saturation
   always_comb begin
      mag     = 32'd0;
      res     = 32'd0;
      res_ovf = 1'b0;
      if (s1_shamt >= 5'd23) begin
         mag = {8'd0, s1_mant24} << (s1_shamt - 5'd23);
      end else begin
         mag = {8'd0, s1_mant24} >> (5'd23 - s1_shamt);
      end
      case (s1_cls)
         FC_ZERO: begin
            res = 32'd0;
         end
         FC_NORM: begin
            res = s1_sign ? (32'd0 - mag) : mag;
         end
         FC_BIG: begin
            if (s1_is_min) begin
               res = INT_MIN;
            end else begin
               res_ovf = 1'b1;
               res     = s1_sign ? INT_MIN : INT_MAX;
            end
         end
         FC_NAN: begin
            res_ovf = 1'b1;
            res     = SAT_NAN ? INT_MAX : INT_MIN;
         end
         default: begin
            res = 32'd0;
         end
      endcase
   end

   // Stage 2: output register, held stable while the consumer stalls
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_valid <= 1'b0;
         dest      <= 32'd0;
         ovf       <= 1'b0;
      end else if (adv2) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            dest <= res;
            ovf  <= res_ovf;
         end
      end
   end

endmodule
